// File: rtl/psoc_audio_pkg.sv
// Shared audio defaults and helpers for the DAC, I2S receiver and audio FIFO.
`ifndef PSOC_FRAME_SLICE
// Channel k of a packed multi-channel frame; channel 0 sits in the LSBs.
`define PSOC_FRAME_SLICE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package psoc_audio_pkg;

  localparam int DEF_SAMPLE_W = 24;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DIV      = 2048;   // 48 kHz from 98.304 MHz

  // Counter width for a modulo-div counter; never below one bit.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  localparam int DEF_DIV_W = div_width(DEF_DIV);

endpackage

// File: rtl/psoc_dsm_channel.sv
// First-order delta-sigma modulator for one channel. The sample is converted to
// offset binary and added to the accumulator every enabled cycle; the carry out
// is the 1-bit output. The accumulator's top bit is exactly the registered carry,
// so it lives in bit_out and only the low SAMPLE_W bits are kept in r_acc.
module psoc_dsm_channel #(
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                bit_out
);

  logic [SAMPLE_W-1:0] w_u;
  logic [SAMPLE_W:0]   w_sum;
  logic [SAMPLE_W-1:0] r_acc;
  logic                r_bit;

  // Signed midscale (0) maps to 2^(SAMPLE_W-1), i.e. 50 % ones density.
  assign w_u   = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};

  // Accumulate while enabled; mute clears the loop so re-enable starts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_bit <= 1'b0;
    end else if (!en) begin
      r_acc <= '0;
      r_bit <= 1'b0;
    end else begin
      r_acc <= w_sum[SAMPLE_W-1:0];
      r_bit <= w_sum[SAMPLE_W];
    end
  end

  assign bit_out = r_bit;

endmodule

// File: rtl/psoc_dac_dsm.sv
// Multi-channel delta-sigma audio DAC front end: sample-rate FIFO read strobe,
// per-channel frame hold (last frame repeats on underrun), saturating underrun
// counter and one modulator per channel.
module psoc_dac_dsm
  import psoc_audio_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DIV      = DEF_DIV,
  parameter int UCNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CHANNELS*SAMPLE_W-1:0] fifo_data,
  input  logic                         fifo_valid,
  output logic                         fifo_ready,
  output logic [CHANNELS-1:0]          dac_out,
  output logic [UCNT_W-1:0]            underrun_cnt,
  input  logic                         underrun_clr
);

  localparam int               DIV_W    = div_width(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0]  r_div_cnt;
  logic [UCNT_W-1:0] r_ucnt;
  logic              w_strobe;

  // One strobe per period; gated by enable so a falling enable cancels it,
  // and by rst so every output reads 0 while reset is held.
  assign w_strobe   = enable & ~rst & (r_div_cnt == '0);
  assign fifo_ready = w_strobe;

  // Sample-period divider: 0..DIV-1 while running, parked at 0 when muted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!enable) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Underrun counter: clear wins over a same-cycle increment; saturates; kept across mute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ucnt <= '0;
    end else if (underrun_clr) begin
      r_ucnt <= '0;
    end else if (w_strobe && !fifo_valid && (r_ucnt != '1)) begin
      r_ucnt <= r_ucnt + UCNT_W'(1);
    end
  end

  assign underrun_cnt = r_ucnt;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SAMPLE_W-1:0] r_hold;

    // Frame hold: load on a valid strobe, otherwise repeat; mute returns to midscale.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hold <= '0;
      end else if (!enable) begin
        r_hold <= '0;
      end else if (w_strobe && fifo_valid) begin
        r_hold <= `PSOC_FRAME_SLICE(fifo_data, gi, SAMPLE_W);
      end
    end

    psoc_dsm_channel #(
      .SAMPLE_W (SAMPLE_W)
    ) u_dsm (
      .clk     (clk),
      .rst     (rst),
      .en      (enable),
      .sample  (r_hold),
      .bit_out (dac_out[gi])
    );
  end

endmodule

// File: doc/psoc_dac_dsm.md
# psoc_dac_dsm

Parametrised audio DAC front end; it replaces the single-bit dummy DAC. It generates the sample-rate read strobe for the audio FIFO, latches one multi-channel frame per sample period and holds the last frame on underrun. Each channel drives a first-order delta-sigma modulator whose 1-bit output feeds an external RC filter (FPGA pin or ASIC pad). It sits between the audio FIFO and the analog/phone outputs.

## Interface
- SAMPLE_W, 24: bits per channel sample, two's complement; legal range 4–32.
- CHANNELS, 2: channel count, 1–8; channel 0 = left, 1 = right.
- DIV, 2048: clk cycles per sample period, ≥ 4 (2048 gives 48 kHz at 98.304 MHz).
- UCNT_W, 16: underrun counter width.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run/mute; low clears the datapath.
- fifo_data  in  CHANNELS*SAMPLE_W  frame; channel k at bits [k*SAMPLE_W +: SAMPLE_W].
- fifo_valid  in  1  FIFO non-empty; fifo_data is valid.
- fifo_ready  out  1  one-cycle read strobe; pops one frame when fifo_valid is high.
- dac_out  out  CHANNELS  registered 1-bit modulator outputs.
- underrun_cnt  out  UCNT_W  saturating count of strobes that found fifo_valid low.
- underrun_clr  in  1  synchronous clear of underrun_cnt.

## Operation
- Divider:
  - Counter `div_cnt` is $clog2(DIV) bits, counts 0..DIV-1 and wraps to 0.
  - It advances only while enable = 1.
  - While enable = 0 it is forced to 0.
- fifo_ready = enable & (div_cnt == 0); it is combinational from registers, so exactly one cycle per period.
- Frame capture, on a strobe cycle:
  - fifo_valid = 1: frame latched into `hold[k]` at the next edge.
  - fifo_valid = 0: `hold` unchanged (last frame repeats); underrun_cnt += 1, saturating at all-ones.
- underrun_clr has priority over an increment in the same cycle.
- Modulator, per channel:
  - u = hold[k] with the MSB inverted (offset binary).
  - `acc` is SAMPLE_W+1 bits; each cycle with enable = 1: sum = acc[SAMPLE_W-1:0] + u, acc <= sum.
  - dac_out[k] <= sum[SAMPLE_W] (the carry).
  - Mean density of ones = u / 2^SAMPLE_W.
- enable = 0:
  - acc, dac_out and div_cnt are cleared synchronously; hold is cleared to 0 (signed midscale).
  - underrun_cnt is retained.
- Reset: all outputs 0; div_cnt, hold, acc and underrun_cnt are 0.
- Simultaneous strobe and enable falling edge: no strobe occurs (fifo_ready is gated by enable), no frame is latched, no underrun is counted.

## Timing
- First fifo_ready is in the first cycle with enable = 1 after reset or re-enable (div_cnt = 0). Later strobes follow every DIV cycles.
- Frame latency:
  - Frame accepted at edge T is in hold after T.
  - It first affects acc at edge T+1.
  - It is first visible on dac_out after edge T+1.
- Arithmetic is unsigned, with no truncation beyond the discarded carry.
- Accumulator wrap is intended behaviour; no overflow flag.
- Full-scale negative (MSB set, rest 0) gives constant 0.
- Full-scale positive gives 1 except one 0 per 2^SAMPLE_W cycles.
- Reset deasserted mid-period restarts the divider at 0. The async assert takes effect immediately; deassertion is expected synchronous to clk (synchroniser upstream).

## Structure
- Shared include `psoc_audio_pkg`:
  - default SAMPLE_W, CHANNELS, DIV;
  - localparam for divider width;
  - frame slice helper macro, shared with the I2S receiver and FIFO.
- Sub-module `psoc_dsm_channel` (SAMPLE_W parameter; ports clk, rst, en, sample, bit_out). It holds one accumulator and the output flop and is instantiated CHANNELS times in a generate loop.
- Divider, hold registers and underrun counter stay in the top.

## Test plan
- Reset and idle:
  - Assert rst mid-cycle, hold enable = 0.
  - Expect: fifo_ready, dac_out and underrun_cnt are 0 immediately and stay 0 for 100 cycles.
- Strobe period (DIV = 16, enable = 1, fifo_valid = 1):
  - fifo_ready high at cycles 0, 16, 32; never two consecutive cycles.
  - Drop enable at cycle 20, re-raise at 40: next strobe at cycle 40.
- Modulator values (SAMPLE_W = 8, CHANNELS = 2), frame {ch1 = 0x80, ch0 = 0x00}:
  - ch0 alternates 0,1,0,1… starting with 0.
  - ch1 stays 0.
  - Frame ch0 = 0x7F: 255 ones in every 256 cycles, first output 0.
- Density sweep: random signed samples held for 4096 cycles; ones count within ±1 of (u × 4096)/256 per channel.
- Underrun:
  - fifo_valid low for 3 strobes after frame 0x40: dac_out keeps the 0x40 density and underrun_cnt = 3.
  - With UCNT_W = 2 and 5 underruns: saturates at 3.
  - underrun_clr coinciding with an underrun strobe gives 0.
- Mid-operation disable/reset:
  - Drop enable mid-frame: dac_out = 0 next cycle, hold = 0, underrun_cnt retained.
  - Assert rst while accumulators are nonzero: all state 0 immediately.
